// File: rtl/dmem_lsu_master.sv
// Load/store master for a word-addressed synchronous data memory.
// Byte/half/word loads with extension; sub-word stores via read-modify-write.
module dmem_lsu_master #(
  parameter int MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [31:0] LP_DEPTH = 32'(MEM_DEPTH);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_din;

  logic        w_misalign;
  logic        w_bad_size;
  logic        w_oor;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [31:0] w_merge;

  // Request error screening, evaluated on the raw request in IDLE
  always_comb begin
    w_bad_size = (req_size == 2'b11);
    w_misalign = 1'b0;
    if (req_size == 2'b01)
      w_misalign = req_addr[0];
    else if (req_size == 2'b10)
      w_misalign = (req_addr[1:0] != 2'b00);
    w_oor = ({2'b00, req_addr[31:2]} >= LP_DEPTH);
    w_err = w_bad_size | w_misalign | w_oor;
  end

  // Lane extraction and extension of the word returned by memory
  always_comb begin
    w_byte = mem_dout[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_dout[31:16] : mem_dout[15:0];
    w_ld   = mem_dout;
    if (r_size == 2'b00)
      w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
    else if (r_size == 2'b01)
      w_ld = {{16{~r_uns & w_half[15]}}, w_half};
  end

  // Replace the addressed lane of the read word with the store data
  always_comb begin
    w_merge = mem_dout;
    if (r_size == 2'b00)
      w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else if (r_off[1])
      w_merge[31:16] = r_wdata;
    else
      w_merge[15:0] = r_wdata;
  end

  // Control FSM with latched request fields and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_uns;
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata[15:0];
            r_addr  <= {2'b00, req_addr[31:2]};
            r_err   <= w_err;
            if (w_err) begin
              r_state <= S_RESP;
            end else if (req_we && req_size == 2'b10) begin
              r_din   <= req_wdata;
              r_state <= S_WR;
            end else begin
              r_state <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: r_state <= S_RD_DATA;
        S_RD_DATA: begin
          if (r_we) begin
            r_din   <= w_merge;
            r_state <= S_WR;
          end else begin
            r_rdata <= w_ld;
            r_state <= S_RESP;
          end
        end
        S_WR:    r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_RESP);
  assign mem_we   = (r_state == S_WR);
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign mem_addr = r_addr;
  assign mem_din  = r_din;

endmodule
